serial_tx: RTL

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 101 ++++++++++
 1 files changed

// File: rtl/serial_tx.sv
// Frames a parallel word as start(1), WIDTH data bits LSB first, even parity; DIV cycles per bit, done pulses (WIDTH+2)*DIV+1 cycles after accept.
// in_ready only in IDLE/DONE; in_valid otherwise ignored without buffering. tx_d/tx_en drive a downstream enabled D flip-flop chain.
module serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx_d,
  output logic             tx_en,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(DIV + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             parity;
  logic [BW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic             period_end;
  logic             accept;

  assign period_end = (div_cnt == LAST_DIV);
  assign accept     = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    tx_d      = 1'b0;
    tx_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = START;
      end
      START: begin
        busy  = 1'b1;
        tx_d  = 1'b1;
        tx_en = period_end;
        if (period_end) state_nxt = DATA;
      end
      DATA: begin
        busy  = 1'b1;
        tx_d  = shreg[0];
        tx_en = period_end;
        if (period_end && (bit_cnt == LAST_BIT)) state_nxt = PARITY;
      end
      PARITY: begin
        busy  = 1'b1;
        tx_d  = parity;
        tx_en = period_end;
        if (period_end) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        in_ready  = 1'b1;
        state_nxt = in_valid ? START : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Parity is taken from the word at accept so later in_data changes cannot leak in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      parity  <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (accept) begin
      shreg   <= in_data;
      parity  <= ^in_data;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (busy) begin
      div_cnt <= period_end ? '0 : div_cnt + 1'b1;
      if ((state == DATA) && period_end) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule
